// File: rtl/freq_measure_ctrl_if.sv
// Handshake and result bus of the frequency measurement controller.
// The master side (host / testbench) drives requests and the signal under test;
// the slave side (controller) drives the generator select and the result.
interface freq_measure_ctrl_if #(
  parameter int CNT_W = 24
);
  logic             start;
  logic             auto_en;
  logic [1:0]       man_mode;
  logic             sigIn;
  logic [1:0]       testmode;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic [1:0]       result_mode;
  logic             result_valid;
  logic             overflow;

  modport master (
    output start, auto_en, man_mode, sigIn,
    input  testmode, busy, result, result_mode, result_valid, overflow
  );

  modport slave (
    input  start, auto_en, man_mode, sigIn,
    output testmode, busy, result, result_mode, result_valid, overflow
  );
endinterface

// File: rtl/freq_measure_ctrl.sv
// Frequency measurement controller: selects a testmode on the signal
// generator, waits for it to settle, counts rising edges of sigIn over a fixed
// gate window and publishes a saturating count. In auto mode it rotates
// through all four testmodes continuously.
module freq_measure_ctrl #(
  parameter int GATE_CYCLES   = 50000000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 24
) (
  input  logic                sysclk,
  input  logic                resetb,
  freq_measure_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] GATE   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Window counters run 0 .. N-1, so clog2(N) bits suffice (minimum one bit).
  localparam int GATE_W   = (GATE_CYCLES   > 1) ? $clog2(GATE_CYCLES)   : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  logic [1:0]          state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    edge_cnt;
  logic                ovf_flag;

  logic                sync_1;
  logic                sync_q;
  logic                delay_q;
  logic                sig_rise;

  logic [CNT_W-1:0]    edge_cnt_next;
  logic                ovf_flag_next;

  // Bring sigIn into the sysclk domain and keep one delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      sync_1  <= 1'b0;
      sync_q  <= 1'b0;
      delay_q <= 1'b0;
    end else begin
      sync_1  <= bus.sigIn;
      sync_q  <= sync_1;
      delay_q <= sync_q;
    end
  end

  assign sig_rise = sync_q & ~delay_q;

  // Saturating edge count for this cycle; an increment attempt at the maximum raises the flag.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    edge_cnt_next = edge_cnt;
    ovf_flag_next = ovf_flag;
    if (sig_rise) begin
      if (edge_cnt == CNT_MAX) begin
        ovf_flag_next = 1'b1;
      end else begin
        edge_cnt_next = edge_cnt + 1'b1;
      end
    end
  end

  // Measurement sequencer with fully registered outputs.
  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      gate_cnt         <= '0;
      edge_cnt         <= '0;
      ovf_flag         <= 1'b0;
      bus.testmode     <= 2'b00;
      bus.busy         <= 1'b0;
      bus.result       <= '0;
      bus.result_mode  <= 2'b00;
      bus.result_valid <= 1'b0;
      bus.overflow     <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Manual shots take the requested mode; auto runs resume the rotation.
            if (!bus.auto_en) begin
              bus.testmode <= bus.man_mode;
            end
            settle_cnt <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_flag   <= 1'b0;
            bus.busy   <= 1'b1;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= GATE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        GATE: begin
          edge_cnt <= edge_cnt_next;
          ovf_flag <= ovf_flag_next;
          if (gate_cnt == GATE_LAST) begin
            // Publish the "next" values so an edge seen in the final gate cycle counts.
            bus.result       <= edge_cnt_next;
            bus.overflow     <= ovf_flag_next;
            bus.result_mode  <= bus.testmode;
            bus.result_valid <= 1'b1;
            state            <= DONE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end

        DONE: begin
          if (bus.auto_en) begin
            bus.testmode <= bus.testmode + 2'd1;
            settle_cnt   <= '0;
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            ovf_flag     <= 1'b0;
            state        <= SETTLE;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Directed testbench for freq_measure_ctrl with a short gate window
// (GATE_CYCLES=1000, SETTLE_CYCLES=8) and a 4-bit counter to reach saturation.
module tb_freq_measure_ctrl;

  localparam int GATE   = 1000;
  localparam int SETTLE = 8;
  localparam int BUSY_LEN = SETTLE + GATE + 1;

  logic sysclk;
  logic resetb;

  freq_measure_ctrl_if #(.CNT_W(4)) bus ();

  freq_measure_ctrl #(
    .GATE_CYCLES  (GATE),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (4)
  ) dut (
    .sysclk(sysclk),
    .resetb(resetb),
    .bus   (bus.slave)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  // sigIn generator: either a periodic square wave or a one-off pulse, driven 2 ns after posedge.
  int sig_period = 0;
  int sig_ph = 0;
  int sig_pulse = 0;

  initial begin
    bus.sigIn = 1'b0;
    forever begin
      @(posedge sysclk);
      #2;
      if (sig_pulse > 0) begin
        bus.sigIn = 1'b1;
        sig_pulse--;
      end else if (sig_period > 0) begin
        bus.sigIn = (sig_ph < sig_period / 2);
        sig_ph = (sig_ph + 1 >= sig_period) ? 0 : sig_ph + 1;
      end else begin
        bus.sigIn = 1'b0;
      end
    end
  end

  // Count every result_valid cycle seen.
  always @(negedge sysclk) begin
    if (bus.result_valid === 1'b1) valid_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_period(input int p);
    sig_period = p;
    sig_ph = 0;
  endtask

  // One manual shot: pulse start, report testmode seen, busy length and result_valid pulses.
  task automatic run_shot(input logic [1:0] mm, output logic [1:0] tm, output int blen, output int nv);
    int v0;
    @(negedge sysclk);
    bus.auto_en  = 1'b0;
    bus.man_mode = mm;
    bus.start    = 1'b1;
    @(negedge sysclk);
    bus.start = 1'b0;
    tm = bus.testmode;
    v0 = valid_cnt;
    blen = 0;
    while (bus.busy === 1'b1 && blen < 3000) begin
      blen++;
      @(negedge sysclk);
    end
    nv = valid_cnt - v0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (bus.result_valid !== 1'b1 && n < 3000);
    check("valid_seen", bus.result_valid, 1);
  endtask

  // Manual shot with a single sigIn pulse scheduled at negedge nk after the start edge.
  task automatic edge_shot(input int nk, input logic [3:0] exp_r, input string name);
    int n;
    int v0;
    @(negedge sysclk);
    bus.auto_en  = 1'b0;
    bus.man_mode = 2'b00;
    bus.start    = 1'b1;
    @(negedge sysclk);
    bus.start = 1'b0;
    v0 = valid_cnt;
    repeat (nk - 1) @(negedge sysclk);
    sig_pulse = 3;
    n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    check({name, "_busy_drop"}, bus.busy, 0);
    check({name, "_result"}, bus.result, exp_r);
    check({name, "_nvalid"}, valid_cnt - v0, 1);
  endtask

  typedef struct {
    logic [1:0] mm;
    int         period;
    logic [3:0] exp_result;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0] tm;
    int blen;
    int nv;
    int n;
    int v0;

    // period P divides the 1000-cycle gate, so exactly 1000/P edges land in it.
    vecs[0] = '{2'b01,  100, 4'd10, 1'b0};
    vecs[1] = '{2'b10,   50, 4'd15, 1'b1};
    vecs[2] = '{2'b11,  200, 4'd5,  1'b0};
    vecs[3] = '{2'b00,    0, 4'd0,  1'b0};
    vecs[4] = '{2'b10,  125, 4'd8,  1'b0};
    vecs[5] = '{2'b01, 1000, 4'd1,  1'b0};
    vecs[6] = '{2'b11,  250, 4'd4,  1'b0};
    vecs[7] = '{2'b10,    2, 4'd15, 1'b1};

    resetb       = 1'b0;
    bus.start    = 1'b0;
    bus.auto_en  = 1'b0;
    bus.man_mode = 2'b00;

    repeat (3) @(negedge sysclk);
    check("rst_testmode", bus.testmode, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    check("rst_result_mode", bus.result_mode, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    resetb = 1'b1;

    // Table-driven manual shots.
    for (int i = 0; i < 8; i++) begin
      set_period(vecs[i].period);
      repeat (20) @(negedge sysclk);
      run_shot(vecs[i].mm, tm, blen, nv);
      check($sformatf("v%0d_testmode", i), tm, vecs[i].mm);
      check($sformatf("v%0d_busy_len", i), blen, BUSY_LEN);
      check($sformatf("v%0d_nvalid", i), nv, 1);
      check($sformatf("v%0d_result", i), bus.result, vecs[i].exp_result);
      check($sformatf("v%0d_result_mode", i), bus.result_mode, vecs[i].mm);
      check($sformatf("v%0d_overflow", i), bus.overflow, vecs[i].exp_ovf);
    end

    // Result registers hold between updates.
    repeat (50) @(negedge sysclk);
    check("hold_result", bus.result, 15);
    check("hold_overflow", bus.overflow, 1);
    check("hold_result_mode", bus.result_mode, 2);
    check("hold_valid_low", bus.result_valid, 0);

    // Asynchronous reset in the middle of a gate window.
    set_period(100);
    repeat (20) @(negedge sysclk);
    bus.man_mode = 2'b11;
    bus.start    = 1'b1;
    @(negedge sysclk);
    bus.start = 1'b0;
    repeat (500) @(negedge sysclk);
    check("pre_rst_busy", bus.busy, 1);
    v0 = valid_cnt;
    #1 resetb = 1'b0;
    #1;
    check("mid_rst_testmode", bus.testmode, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_result_mode", bus.result_mode, 0);
    check("mid_rst_result_valid", bus.result_valid, 0);
    check("mid_rst_overflow", bus.overflow, 0);
    @(negedge sysclk);
    resetb = 1'b1;
    repeat (1200) @(negedge sysclk);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_no_valid", valid_cnt - v0, 0);

    // Auto rotation from a single start pulse.
    @(negedge sysclk);
    bus.auto_en = 1'b1;
    bus.start   = 1'b1;
    @(negedge sysclk);
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_valid(n);
      check($sformatf("auto%0d_mode", k), bus.result_mode, k % 4);
      check($sformatf("auto%0d_result", k), bus.result, 10);
      if (k > 0) check($sformatf("auto%0d_interval", k), n, BUSY_LEN);
    end

    // auto_en dropped mid-measurement: that run completes, then idle.
    repeat (500) @(negedge sysclk);
    bus.auto_en = 1'b0;
    wait_valid(n);
    check("auto_stop_mode", bus.result_mode, 1);
    check("auto_stop_result", bus.result, 10);
    @(negedge sysclk);
    check("auto_stop_busy", bus.busy, 0);
    repeat (100) @(negedge sysclk);
    check("auto_stop_still_idle", bus.busy, 0);

    // start and man_mode toggling during GATE are ignored.
    @(negedge sysclk);
    bus.man_mode = 2'b10;
    bus.start    = 1'b1;
    @(negedge sysclk);
    bus.start = 1'b0;
    v0 = valid_cnt;
    repeat (300) @(negedge sysclk);
    for (int i = 0; i < 4; i++) begin
      bus.start    = 1'b1;
      bus.man_mode = 2'(i);
      @(negedge sysclk);
      bus.start = 1'b0;
      @(negedge sysclk);
      check($sformatf("ign%0d_testmode", i), bus.testmode, 2);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    check("ign_busy_drop", bus.busy, 0);
    check("ign_nvalid", valid_cnt - v0, 1);
    check("ign_result", bus.result, 10);
    check("ign_result_mode", bus.result_mode, 2);
    repeat (30) @(negedge sysclk);
    check("ign_no_restart", bus.busy, 0);

    // Gate boundaries: edges detected in last SETTLE / first GATE / last GATE / DONE cycles.
    set_period(0);
    repeat (10) @(negedge sysclk);
    edge_shot(5, 4'd0, "edge_in_settle");
    edge_shot(6, 4'd1, "edge_first_gate");
    edge_shot(1006, 4'd0, "edge_in_done");
    edge_shot(1005, 4'd1, "edge_last_gate");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_measure_ctrl.md
FREQ_MEASURE_CTRL -- requirements
Module: freq_measure_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 50000000, gate window length in sysclk cycles (1 s at 50 MHz).
REQ-002 Parameter SETTLE_CYCLES, default 1024, wait after a testmode change before gating.
REQ-003 Parameter CNT_W, default 24, width of the edge counter and result.
REQ-004 sysclk  input  1  50 MHz system clock; all state on its rising edge.
REQ-005 resetb  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request one measurement; sampled every cycle, acted on only in IDLE.
REQ-007 auto_en  input  1  1 = continuous measurement with testmode rotation; 0 = single manual shot.
REQ-008 man_mode  input  2  testmode used for manual measurements.
REQ-009 sigIn  input  1  signal under measurement, asynchronous to sysclk.
REQ-010 testmode  output  2  frequency select driven to the signal generator.
REQ-011 busy  output  1  high in SETTLE, GATE and DONE.
REQ-012 result  output  CNT_W  rising-edge count of the last completed gate.
REQ-013 result_mode  output  2  testmode in effect for the last result.
REQ-014 result_valid  output  1  single-cycle pulse when result is updated.
REQ-015 overflow  output  1  last result saturated.

Function
REQ-016 FSM states: IDLE, SETTLE, GATE, DONE; fully registered outputs.
REQ-017 IDLE with start=1: testmode <= man_mode if auto_en=0, otherwise it keeps its rotation value; next state SETTLE; settle counter cleared.
REQ-018 SETTLE: stay exactly SETTLE_CYCLES cycles, then GATE; edge counter and gate counter cleared on entry.
REQ-019 sigIn: 2-flop synchronizer plus a delay flop; rising edge = sync_q=1 and delay_q=0; counting latency 3 cycles from the sigIn transition.
REQ-020 GATE: lasts exactly GATE_CYCLES cycles; each cycle with a detected rising edge increments the counter by 1.
REQ-021 Counter saturates at 2^CNT_W-1; any increment attempt at the maximum sets an internal overflow flag.
REQ-022 On the edge leaving GATE: result <= count, including an edge detected in the last GATE cycle; result_mode <= testmode; overflow <= flag; result_valid <= 1.
REQ-023 DONE lasts one cycle; result_valid is high only in that cycle.
REQ-024 DONE with auto_en=1: testmode advances 00->01->10->11->00; next state SETTLE, with no start required.
REQ-025 DONE with auto_en=0: next state IDLE; testmode unchanged.
REQ-026 Input changes while busy are ignored: start, man_mode and sigIn edges outside GATE.
REQ-027 auto_en falling mid-measurement: the current measurement completes normally, then IDLE.
REQ-028 result, result_mode and overflow hold their values between updates.

Reset
REQ-029 On resetb=0, immediately and asynchronously:
- state IDLE
- testmode=00, busy=0, result=0, result_mode=00, result_valid=0, overflow=0
- all counters and synchronizer flops cleared
REQ-030 Reset during any state aborts the measurement; no result_valid is produced for it.

Verification
Test parameters unless noted: GATE_CYCLES=1000, SETTLE_CYCLES=8.
REQ-031 Assert resetb=0 mid-GATE -> all outputs at reset values the same cycle; after release, busy=0 and no result_valid.
REQ-032 auto_en=0, man_mode=01, sigIn period 100 cycles, start pulse -> testmode=01, busy for 8+1000+1 cycles, result=10, result_mode=01, result_valid high exactly one cycle.
REQ-033 auto_en=1, single start pulse -> consecutive results with result_mode 00,01,10,11,00, one SETTLE between each.
REQ-034 CNT_W=4, 20 sigIn edges in the gate -> result=15, overflow=1; next run with 5 edges -> result=5, overflow=0.
REQ-035 start pulses and man_mode changes during GATE -> no restart, testmode unchanged, one result only.
REQ-036 sigIn edge detected in the final GATE cycle -> counted; edge detected in the first DONE cycle -> not counted.
